// File: rtl/nand_reduce_pkg.sv
// Shared operator codes and decode helpers for the pipelined reduction cell.
// NAND_REDUCE_XOR_EN enables the XOR base operator (codes 4/5); otherwise those codes act as NAND.
package nand_reduce_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        BASE_AND = 2'd0,
        BASE_OR  = 2'd1,
        BASE_XOR = 2'd2
    } base_e;

    // Reserved codes, and XOR codes when XOR is not built, fall into the NAND default.
    function automatic logic is_inv(input logic [OP_W-1:0] op);
        case (op_e'(op))
            OP_AND, OP_OR: return 1'b0;
`ifdef NAND_REDUCE_XOR_EN
            OP_XOR:        return 1'b0;
`endif
            default:       return 1'b1;
        endcase
    endfunction

    function automatic base_e base_of(input logic [OP_W-1:0] op);
        case (op_e'(op))
            OP_OR, OP_NOR:   return BASE_OR;
`ifdef NAND_REDUCE_XOR_EN
            OP_XOR, OP_XNOR: return BASE_XOR;
`endif
            default:         return BASE_AND;
        endcase
    endfunction

    function automatic logic ident(input base_e base);
        return (base == BASE_AND);
    endfunction

endpackage

// File: rtl/nand_reduce_pipe_if.sv
// Beat-level bus of the reduction cell: input beat channel and result channel.
// Both channels: a beat moves on the rising edge where valid && ready; the sender holds data until then.
interface nand_reduce_pipe_if
    import nand_reduce_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int LANES = 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [OP_W-1:0]       in_op;
    logic [LANES*N_IN-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES-1:0]      out_data;
    logic [OP_W-1:0]       out_op;

    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_op
    );

    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_data, out_op
    );
endinterface

// File: rtl/nand_reduce_stage.sv
// One tree level: pairwise combine of each lane with the beat's base operator, then a register slot.
// NAND_REDUCE_XOR_EN adds the XOR combine path.
module nand_reduce_stage
    import nand_reduce_pkg::*;
#(
    parameter int WIDTH_IN = 2,
    parameter int LANES    = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [OP_W-1:0]                 i_op,
    input  logic [LANES*WIDTH_IN-1:0]       i_data,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [OP_W-1:0]                 o_op,
    output logic [LANES*(WIDTH_IN/2)-1:0]   o_data
);
    localparam int WIDTH_OUT = WIDTH_IN / 2;

    base_e                      w_base;
    logic                       w_load;
    logic [LANES*WIDTH_OUT-1:0] w_comb;

    logic                       r_valid;
    logic [OP_W-1:0]            r_op;
    logic [LANES*WIDTH_OUT-1:0] r_data;

    assign w_base  = base_of(i_op);
    // The slot takes a new beat when empty or when its current beat leaves this edge.
    assign w_load  = !r_valid || i_ready;
    assign o_ready = w_load;

    always_comb begin
        w_comb = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int j = 0; j < WIDTH_OUT; j++) begin
                case (w_base)
                    BASE_OR:  w_comb[k*WIDTH_OUT+j] = i_data[k*WIDTH_IN+2*j] | i_data[k*WIDTH_IN+2*j+1];
`ifdef NAND_REDUCE_XOR_EN
                    BASE_XOR: w_comb[k*WIDTH_OUT+j] = i_data[k*WIDTH_IN+2*j] ^ i_data[k*WIDTH_IN+2*j+1];
`endif
                    default:  w_comb[k*WIDTH_OUT+j] = i_data[k*WIDTH_IN+2*j] & i_data[k*WIDTH_IN+2*j+1];
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= i_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_load && i_valid) begin
            r_op   <= i_op;
            r_data <= w_comb;
        end
    end

    assign o_valid = r_valid;
    assign o_op    = r_op;
    assign o_data  = r_data;

endmodule

// File: rtl/nand_reduce_pipe.sv
// Pipelined N-input, multi-lane reduction (AND/OR/XOR base, optional inversion) with valid/ready.
// NAND_REDUCE_XOR_EN builds XOR/XNOR; without it codes 4/5 behave as NAND.
module nand_reduce_pipe
    import nand_reduce_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int LANES = 1
) (
    input  logic               CLK,
    input  logic               RST,
    nand_reduce_pipe_if.slave  bus
);
    localparam int L  = $clog2(N_IN);
    localparam int P  = 1 << L;
    // All tree levels are packed into one vector: level 0 (padded leaves) first, level L last.
    localparam int TW = LANES * ((2 << L) - 1);
    localparam int LAST_OFF = LANES * ((2 << L) - 2);

    logic                  w_pad;
    logic [LANES*P-1:0]    w_leaves;
    logic                  w_inv;
    logic [LANES-1:0]      w_last;

    wire  [TW-1:0]         w_tree;
    wire  [L:0]            w_valid;
    wire  [L:0]            w_ready;
    wire  [(L+1)*OP_W-1:0] w_op;

    assign w_pad = ident(base_of(bus.in_op));

    always_comb begin
        w_leaves = {(LANES*P){w_pad}};
        for (int k = 0; k < LANES; k++) begin
            for (int j = 0; j < N_IN; j++) begin
                w_leaves[k*P+j] = bus.in_data[k*N_IN+j];
            end
        end
    end

    assign w_tree[LANES*P-1:0] = w_leaves;
    assign w_valid[0]          = bus.in_valid;
    assign w_op[OP_W-1:0]      = bus.in_op;
    assign w_ready[L]          = bus.out_ready;
    assign bus.in_ready        = w_ready[0];

    for (genvar s = 1; s <= L; s++) begin : g_stage
        localparam int WI     = 2 << (L - s);
        localparam int OFF_I  = LANES * ((2 << L) - (2 << (L - s + 1)));
        localparam int OFF_O  = LANES * ((2 << L) - (2 << (L - s)));

        nand_reduce_stage #(
            .WIDTH_IN (WI),
            .LANES    (LANES)
        ) u_stage (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_valid (w_valid[s-1]),
            .o_ready (w_ready[s-1]),
            .i_op    (w_op[(s-1)*OP_W +: OP_W]),
            .i_data  (w_tree[OFF_I +: LANES*WI]),
            .o_valid (w_valid[s]),
            .i_ready (w_ready[s]),
            .o_op    (w_op[s*OP_W +: OP_W]),
            .o_data  (w_tree[OFF_O +: LANES*(WI/2)])
        );
    end

    // Inversion sits after the last register so it never costs a cycle.
    assign w_last        = w_tree[LAST_OFF +: LANES];
    assign w_inv         = is_inv(w_op[L*OP_W +: OP_W]);
    assign bus.out_valid = w_valid[L];
    assign bus.out_data  = w_valid[L] ? (w_last ^ {LANES{w_inv}}) : '0;
    assign bus.out_op    = w_valid[L] ? w_op[L*OP_W +: OP_W] : '0;

endmodule

// File: tb/tb_nand_reduce_pipe.sv
// Bench for nand_reduce_pipe: a 3-input/1-lane and a 5-input/2-lane instance with scoreboards.
module tb_nand_reduce_pipe;
    import nand_reduce_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    nand_reduce_pipe_if #(.N_IN(3), .LANES(1)) b3 ();
    nand_reduce_pipe_if #(.N_IN(5), .LANES(2)) b5 ();

    nand_reduce_pipe #(.N_IN(3), .LANES(1)) dut3 (.CLK(clk), .RST(rst), .bus(b3.slave));
    nand_reduce_pipe #(.N_IN(5), .LANES(2)) dut5 (.CLK(clk), .RST(rst), .bus(b5.slave));

    // Expected {op, out_data}
    logic [3:0] exp_q3[$];
    logic [4:0] exp_q5[$];
    logic [3:0] e3;
    logic [4:0] e5;
    bit done3, done5;

    // Straight fold over the inputs, independent of any tree structure.
    function automatic logic ref_red(input logic [2:0] op, input logic [63:0] bits, input int n);
        logic [2:0] eff;
        logic r;
        eff = (op > 3'd5) ? 3'd1 : op;
`ifndef NAND_REDUCE_XOR_EN
        if (eff == 3'd4 || eff == 3'd5) eff = 3'd1;
`endif
        r = (eff[2:1] == 2'd0);
        for (int i = 0; i < n; i++) begin
            case (eff[2:1])
                2'd0:    r = r & bits[i];
                2'd1:    r = r | bits[i];
                default: r = r ^ bits[i];
            endcase
        end
        return r ^ eff[0];
    endfunction

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (b3.out_valid && b3.out_ready) begin
                n_chk++;
                if (exp_q3.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb3_unexpected: got op=%0d data=%b, required no beat", b3.out_op, b3.out_data);
                end else begin
                    e3 = exp_q3.pop_front();
                    if ({b3.out_op, b3.out_data} !== e3) begin
                        n_fail++;
                        $display("FAIL sb3_beat: got op=%0d data=%b, required op=%0d data=%b",
                                 b3.out_op, b3.out_data, e3[3:1], e3[0]);
                    end
                end
            end else if (!b3.out_valid) begin
                n_chk++;
                if (b3.out_data !== 1'b0 || b3.out_op !== 3'd0) begin
                    n_fail++;
                    $display("FAIL sb3_idle: got op=%0d data=%b, required 0/0", b3.out_op, b3.out_data);
                end
            end
            if (b5.out_valid && b5.out_ready) begin
                n_chk++;
                if (exp_q5.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb5_unexpected: got op=%0d data=%b, required no beat", b5.out_op, b5.out_data);
                end else begin
                    e5 = exp_q5.pop_front();
                    if ({b5.out_op, b5.out_data} !== e5) begin
                        n_fail++;
                        $display("FAIL sb5_beat: got op=%0d data=%b, required op=%0d data=%b",
                                 b5.out_op, b5.out_data, e5[4:2], e5[1:0]);
                    end
                end
            end else if (!b5.out_valid) begin
                n_chk++;
                if (b5.out_data !== 2'b00 || b5.out_op !== 3'd0) begin
                    n_fail++;
                    $display("FAIL sb5_idle: got op=%0d data=%b, required 0/0", b5.out_op, b5.out_data);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input logic [2:0] op, input logic [2:0] d, input logic ex);
        int n;
        n = 0;
        b3.in_valid = 1'b1;
        b3.in_op    = op;
        b3.in_data  = d;
        @(negedge clk);
        while (b3.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (b3.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drive3_timeout: in_ready=%b after %0d cycles, required 1", b3.in_ready, n);
        end else begin
            exp_q3.push_back({op, ex});
        end
        tick();
        b3.in_valid = 1'b0;
    endtask

    task automatic drive5(input logic [2:0] op, input logic [9:0] d, input logic [1:0] ex);
        int n;
        n = 0;
        b5.in_valid = 1'b1;
        b5.in_op    = op;
        b5.in_data  = d;
        @(negedge clk);
        while (b5.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (b5.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drive5_timeout: in_ready=%b after %0d cycles, required 1", b5.in_ready, n);
        end else begin
            exp_q5.push_back({op, ex});
        end
        tick();
        b5.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q3.size() != 0 || exp_q5.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        n_chk++;
        if (exp_q3.size() != 0 || exp_q5.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d beats outstanding, required 0/0", exp_q3.size(), exp_q5.size());
        end
        exp_q3.delete();
        exp_q5.delete();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_chk++; if (b3.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid3: got %b, required 0", b3.out_valid); end
        n_chk++; if (b3.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready3: got %b, required 1", b3.in_ready); end
        n_chk++; if (b3.out_data !== 1'b0) begin n_fail++; $display("FAIL reset_out_data3: got %b, required 0", b3.out_data); end
        n_chk++; if (b3.out_op !== 3'd0) begin n_fail++; $display("FAIL reset_out_op3: got %0d, required 0", b3.out_op); end
        n_chk++; if (b5.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid5: got %b, required 0", b5.out_valid); end
        n_chk++; if (b5.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready5: got %b, required 1", b5.in_ready); end
        n_chk++; if (b5.out_data !== 2'b00) begin n_fail++; $display("FAIL reset_out_data5: got %b, required 00", b5.out_data); end
        n_chk++; if (b5.out_op !== 3'd0) begin n_fail++; $display("FAIL reset_out_op5: got %0d, required 0", b5.out_op); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_nand_latency();
        b3.in_valid = 1'b1; b3.in_op = 3'd1; b3.in_data = 3'b111;
        @(negedge clk);
        n_chk++; if (b3.in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_accept1: got %b, required 1", b3.in_ready); end
        exp_q3.push_back({3'd1, 1'b0});
        tick();
        b3.in_data = 3'b110;
        @(negedge clk);
        n_chk++; if (b3.in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_accept2: got %b, required 1", b3.in_ready); end
        exp_q3.push_back({3'd1, 1'b1});
        tick();
        b3.in_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (b3.out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_first_t2: out_valid=%b, required 1", b3.out_valid); end
        tick();
        @(negedge clk);
        n_chk++; if (b3.out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_second_t3: out_valid=%b, required 1", b3.out_valid); end
        tick();
        @(negedge clk);
        n_chk++; if (b3.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_empty_t4: out_valid=%b, required 0", b3.out_valid); end
        tick();
        drain();
    endtask

    task automatic test_padding();
        drive5(3'd3, {5'b00100, 5'b00000}, 2'b01);
        @(negedge clk);
        n_chk++; if (b5.out_valid !== 1'b0) begin n_fail++; $display("FAIL pad_lat_c1: out_valid=%b, required 0", b5.out_valid); end
        tick();
        @(negedge clk);
        n_chk++; if (b5.out_valid !== 1'b0) begin n_fail++; $display("FAIL pad_lat_c2: out_valid=%b, required 0", b5.out_valid); end
        tick();
        @(negedge clk);
        n_chk++; if (b5.out_valid !== 1'b1) begin n_fail++; $display("FAIL pad_lat_c3: out_valid=%b, required 1", b5.out_valid); end
        tick();
        drive5(3'd0, {5'b11110, 5'b11111}, 2'b01);
        drive5(3'd1, {5'b11111, 5'b01111}, 2'b01);
        drive5(3'd2, {5'b10000, 5'b00000}, 2'b10);
        drive3(3'd2, 3'b000, 1'b0);
        drive3(3'd0, 3'b111, 1'b1);
        drain();
    endtask

    task automatic test_xor_codes();
        drive3(3'd5, 3'b011, 1'b1);
        drive3(3'd5, 3'b111, 1'b0);
`ifdef NAND_REDUCE_XOR_EN
        drive3(3'd4, 3'b011, 1'b0);
        drive5(3'd4, {5'b00111, 5'b00001}, 2'b11);
`else
        drive3(3'd4, 3'b011, 1'b1);
        drive5(3'd4, {5'b00111, 5'b11111}, 2'b10);
`endif
        drive3(3'd6, 3'b111, 1'b0);
        drive3(3'd7, 3'b010, 1'b1);
        drain();
    endtask

    task automatic test_alternating();
        drive3(3'd0, 3'b101, 1'b0);
        drive3(3'd2, 3'b101, 1'b1);
        drive3(3'd1, 3'b101, 1'b1);
        drive3(3'd3, 3'b101, 1'b0);
        drain();
    endtask

    task automatic test_backpressure();
        logic [2:0] ops [4];
        int acc;
        ops = '{3'd1, 3'd2, 3'd0, 3'd3};
        acc = 0;
        b3.out_ready = 1'b0;
        b3.in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b3.in_op   = ops[acc % 4];
            b3.in_data = 3'(acc * 3 + 1);
            @(negedge clk);
            if (b3.in_ready) begin
                exp_q3.push_back({b3.in_op, ref_red(b3.in_op, 64'(b3.in_data), 3)});
                acc++;
            end
            tick();
        end
        b3.in_valid = 1'b0;
        n_chk++; if (acc != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d beats, required 2", acc); end
        @(negedge clk);
        n_chk++; if (b3.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %b, required 0", b3.in_ready); end
        n_chk++;
        if (b3.out_valid !== 1'b1 || {b3.out_op, b3.out_data} !== exp_q3[0]) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b op=%0d data=%b, required v=1 op=%0d data=%b",
                     b3.out_valid, b3.out_op, b3.out_data, exp_q3[0][3:1], exp_q3[0][0]);
        end
        tick();
        // release backpressure while offering a new beat: accept and emit in the same cycle
        b3.out_ready = 1'b1;
        b3.in_valid  = 1'b1;
        b3.in_op     = 3'd3;
        b3.in_data   = 3'b000;
        @(negedge clk);
        n_chk++; if (b3.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b, required 1", b3.in_ready); end
        exp_q3.push_back({3'd3, 1'b1});
        tick();
        b3.in_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_inflight();
        b3.out_ready = 1'b0;
        drive3(3'd0, 3'b111, 1'b1);
        drive3(3'd2, 3'b000, 1'b0);
        rst = 1'b1;
        exp_q3.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (b3.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flight_valid: got %b, required 0", b3.out_valid); end
        n_chk++; if (b3.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_flight_ready: got %b, required 1", b3.in_ready); end
        tick();
        b3.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++; if (b3.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale_beat: out_valid=%b at cycle %0d, required 0", b3.out_valid, i); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        done3 = 1'b0;
        done5 = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [2:0] op, d;
                    op = 3'($urandom_range(0, 7));
                    d  = 3'($urandom_range(0, 7));
                    drive3(op, d, ref_red(op, 64'(d), 3));
                    if (i >= 20) repeat ($urandom_range(0, 2)) tick();
                end
                done3 = 1'b1;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [2:0] op;
                    logic [9:0] d;
                    op = 3'($urandom_range(0, 7));
                    d  = 10'($urandom_range(0, 1023));
                    drive5(op, d, {ref_red(op, 64'(d[9:5]), 5), ref_red(op, 64'(d[4:0]), 5)});
                end
                done5 = 1'b1;
            end
            begin
                while (!(done3 && done5)) begin
                    b3.out_ready = 1'($urandom_range(0, 1));
                    b5.out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        b3.out_ready = 1'b1;
        b5.out_ready = 1'b1;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        b3.in_valid  = 1'b0; b3.in_op = 3'd0; b3.in_data = '0; b3.out_ready = 1'b1;
        b5.in_valid  = 1'b0; b5.in_op = 3'd0; b5.in_data = '0; b5.out_ready = 1'b1;
        test_reset();
        test_nand_latency();
        test_padding();
        test_xor_codes();
        test_alternating();
        test_backpressure();
        test_reset_inflight();
        test_back_to_back();
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nand_reduce_pipe.md
# nand_reduce_pipe

Parametrised, pipelined N-input logic-reduction cell with optional output inversion. It generalises the fixed three-input NAND cell to any input count and any number of independent lanes, and adds a runtime-selectable reduction operator. A registered binary tree with a valid/ready handshake lets it sit between synthesised datapath stages without meeting the whole reduction in one cycle.

## Interface
- `N_IN`, 3: reduction inputs per lane; legal range 2..64.
- `LANES`, 1: independent lanes, each reduced separately; legal range 1..32.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: block accepts the beat this cycle.
- `in_op` in 3: operator for this beat; 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR; 6 and 7 are reserved.
- `in_data` in `LANES*N_IN`: lane k occupies bits `[k*N_IN +: N_IN]`.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out `LANES`: bit k is the reduction of lane k.
- `out_op` out 3: operator that produced `out_data`.

## Operation
- Tree depth is `L = clog2(N_IN)`. Each level combines pairs with the base operator: AND for codes 0/1, OR for 2/3, XOR for 4/5. Each level is followed by a register, so there are L pipeline stages.
- Leaves are padded up to `2^L` with the identity of the base operator: 1 for AND, 0 for OR and XOR. Padding is chosen per beat from `in_op`.
- Inversion applies to odd codes (NAND, NOR, XNOR). It is applied combinationally on the last stage's output; it never adds a cycle.
- Reserved codes 6 and 7 are accepted and treated as code 1 (NAND).
- Each stage holds `{valid, op, partial[LANES*2^(L-s)]}`. Stage s loads from stage s-1 when it is empty or is emitting this cycle. This per-stage flow collapses bubbles.
- `in_ready` = stage-1 empty OR stage-1 advancing. The output side is the last stage: `out_valid` is its valid bit.
- A beat transfers on `valid && ready` at either port. Data, op and valid move together; op travels with its beat.
- Operator changes between consecutive beats are legal. There is no drain or flush requirement.

## Timing
- Latency: a beat accepted in cycle t appears at the output in cycle t+L when there is no backpressure. For N_IN=3, L=2.
- Throughput: one beat per cycle while `out_ready=1`.
- Backpressure: with `out_ready=0`, the last stage holds. Upstream stages keep filling until full. `in_ready` drops once all L stages are valid, and rises in the same cycle `out_ready` returns to 1.
- Simultaneous input accept and output emit while full is legal. Occupancy stays at L and no beat is lost or duplicated.
- Reset: `RST` sampled high clears every stage valid. The outputs then read `out_valid=0`, `in_ready=1`, `out_data=0` and `out_op=0`. In-flight beats are discarded and none emerges after reset. Data registers need not be reset but must read 0 at the output while invalid.
- `out_data` and `out_op` are held stable while `out_valid=1 && out_ready=0`.

## Configuration
- `NAND_REDUCE_XOR_EN` defined: the XOR tree and codes 4/5 are built as described.
- Not defined: no XOR logic is generated. Codes 4/5 decode as code 1 (NAND), and the padding identity for them is 1.

## Structure
- Shared package `nand_reduce_pkg` holds:
  - the `op_e` enum for the 3-bit codes;
  - an `is_inv(op)` function;
  - a `base_of(op)` function returning AND/OR/XOR;
  - an `ident(base)` function;
  - the constant `OP_W = 3`.
- Sub-module `nand_reduce_stage` implements one tree level plus its register and valid/advance logic. It takes parameters `WIDTH_IN` and `LANES`. The top instantiates it L times in a generate loop.
- Special case N_IN=2 (L=1): a single stage.

## Test plan
- N_IN=3, LANES=1, `out_ready=1`, beats {op NAND, data 3'b111} then {NAND, 3'b110} -> out_data 0 then 1, at cycles t+2 and t+3.
- N_IN=5, LANES=2, op NOR, lane0=5'b00000, lane1=5'b00100 -> out_data 2'b01 after 3 cycles. This checks that padding leaves do not disturb OR.
- `NAND_REDUCE_XOR_EN` defined, N_IN=3, op XNOR, data 3'b011 -> out_data 1. With the macro undefined, the same beat -> out_data 1 via NAND. With data 3'b111 -> 0 in both builds.
- Hold `out_ready=0` while driving continuous valid beats -> exactly L beats accepted, `in_ready=0` thereafter. Release `out_ready` -> results emerge in order with no loss, and out_op matches each beat.
- Alternate op every beat (AND, OR, NAND, NOR) on 3'b101 -> outputs 0, 1, 1, 0, with out_op tracking.
- Assert `RST` for one cycle with 2 beats in flight -> next cycle out_valid=0 and in_ready=1, and no stale beat ever appears.
